// File: rtl/apb_dma_reg_bridge_if.sv
// APB4 signal bundle between a bus master and the DMA register bridge.
interface apb_dma_reg_bridge_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_dma_reg_bridge.sv
// APB4 slave front-end for the DMA register block: window decode, error response,
// read-latency hiding and byte-strobe writes via read-modify-write.
module apb_dma_reg_bridge #(
  parameter logic [31:0]         BASE_ADDR = 32'h400,
  parameter int unsigned         NUM_REGS  = 10,
  parameter logic [NUM_REGS-1:0] RO_MASK   = 10'h060,
  parameter logic [NUM_REGS-1:0] W1C_MASK  = 10'h100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  apb_dma_reg_bridge_if.slave  apb,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [31:0]          addr,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata,
  output logic [7:0]           err_count
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ERR       = 4'd1;
  localparam logic [3:0] WR        = 4'd2;
  localparam logic [3:0] RD_ISSUE  = 4'd3;
  localparam logic [3:0] RD_CAP    = 4'd4;
  localparam logic [3:0] RD_RESP   = 4'd5;
  localparam logic [3:0] RMW_ISSUE = 4'd6;
  localparam logic [3:0] RMW_CAP   = 4'd7;
  localparam logic [3:0] RMW_WR    = 4'd8;

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // BASE_ADDR is word aligned, so the word offset is a plain 30-bit subtract.
  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
  localparam logic [29:0] NUM_W  = 30'(NUM_REGS);

  logic [3:0]  state;
  logic [31:0] pwdata_q;
  logic [3:0]  strb_q;
  logic        w1c_q;

  logic [29:0] word_off;
  logic        in_range;
  logic        ro_hit;
  logic        w1c_hit;
  logic        valid;
  logic [31:0] merged;

  always_comb begin
    word_off = apb.paddr[31:2] - BASE_W;
    in_range = (apb.paddr >= BASE_ADDR) && (word_off < NUM_W);
    ro_hit   = in_range && RO_MASK[word_off[IDX_W-1:0]];
    w1c_hit  = in_range && W1C_MASK[word_off[IDX_W-1:0]];
    valid    = in_range && (apb.paddr[1:0] == 2'b00) && !(apb.pwrite && ro_hit);
  end

  // Unstrobed lanes of a W1C register are written as zero so the merge never
  // clears flags that happened to read back as set.
  always_comb begin
    merged = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb_q[b])
        merged[8*b +: 8] = pwdata_q[8*b +: 8];
      else if (w1c_q)
        merged[8*b +: 8] = 8'h00;
      else
        merged[8*b +: 8] = rdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      apb.prdata  <= '0;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      err_count   <= '0;
      pwdata_q    <= '0;
      strb_q      <= '0;
      w1c_q       <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      rd_en       <= 1'b0;
      apb.pready  <= 1'b0;
      apb.pslverr <= 1'b0;
      apb.prdata  <= '0;
      case (state)
        IDLE: begin
          if (apb.psel && apb.penable) begin
            addr     <= apb.paddr;
            pwdata_q <= apb.pwdata;
            strb_q   <= apb.pstrb;
            w1c_q    <= w1c_hit;
            if (!valid) begin
              state       <= ERR;
              apb.pready  <= 1'b1;
              apb.pslverr <= 1'b1;
              if (err_count != '1)
                err_count <= err_count + 8'd1;
            end else if (apb.pwrite && apb.pstrb == 4'hF) begin
              state      <= WR;
              wr_en      <= 1'b1;
              wdata      <= apb.pwdata;
              apb.pready <= 1'b1;
            end else if (apb.pwrite && apb.pstrb == 4'h0) begin
              state      <= ERR;
              apb.pready <= 1'b1;
            end else if (apb.pwrite) begin
              state <= RMW_ISSUE;
              rd_en <= 1'b1;
            end else begin
              state <= RD_ISSUE;
              rd_en <= 1'b1;
            end
          end
        end
        RD_ISSUE:  state <= RD_CAP;
        RD_CAP: begin
          state      <= RD_RESP;
          apb.prdata <= rdata;
          apb.pready <= 1'b1;
        end
        RMW_ISSUE: state <= RMW_CAP;
        RMW_CAP: begin
          state      <= RMW_WR;
          wdata      <= merged;
          wr_en      <= 1'b1;
          apb.pready <= 1'b1;
        end
        ERR, WR, RD_RESP, RMW_WR: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_dma_reg_bridge.sv
// Scoreboard bench for apb_dma_reg_bridge with a behavioural DMA register block.
module tb_apb_dma_reg_bridge;

  typedef struct packed {
    logic [3:0]  rdy_cyc;
    logic [3:0]  wr_cyc;
    logic [3:0]  wr_n;
    logic [3:0]  rd_cyc;
    logic [3:0]  rd_n;
    logic        slverr;
    logic [31:0] prdata;
    logic [31:0] wdata;
    logic [31:0] addr;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  apb_dma_reg_bridge_if apb();
  logic        wr_en, rd_en;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  err_count;

  apb_dma_reg_bridge #(
    .BASE_ADDR(32'h400),
    .NUM_REGS (10),
    .RO_MASK  (10'h060),
    .W1C_MASK (10'h100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .apb      (apb),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .err_count(err_count)
  );

  // Register block model: one-cycle registered read, ERROR_STATUS is W1C.
  logic [31:0] regs [10];
  logic        bd_en = 1'b0;
  int unsigned bd_idx = 0;
  logic [31:0] bd_val = '0;

  function automatic int unsigned reg_idx(input logic [31:0] a);
    return (a - 32'h400) >> 2;
  endfunction

  always @(posedge clk) begin
    if (bd_en)
      regs[bd_idx] <= bd_val;
    if (wr_en && reg_idx(addr) < 10) begin
      if (reg_idx(addr) == 8)
        regs[8] <= regs[8] & ~wdata;
      else
        regs[reg_idx(addr)] <= wdata;
    end
    if (rd_en && reg_idx(addr) < 10)
      rdata <= regs[reg_idx(addr)];
  end

  int wr_total = 0, rd_total = 0, rdy_total = 0;
  always @(negedge clk) begin
    if (wr_en) wr_total++;
    if (rd_en) rd_total++;
    if (apb.pready) rdy_total++;
  end

  xfer_t exp_q[$];
  xfer_t o, e;
  int n_err = 0, n_chk = 0;
  int exp_err = 0;

  function automatic xfer_t mk(input int rdy, input int wr, input int rd, input logic err,
                               input logic [31:0] pr, input logic [31:0] wd, input logic [31:0] ad);
    xfer_t x = '0;
    x.rdy_cyc = 4'(rdy);
    x.wr_cyc  = 4'(wr);
    x.wr_n    = (wr != 0) ? 4'd1 : 4'd0;
    x.rd_cyc  = 4'(rd);
    x.rd_n    = (rd != 0) ? 4'd1 : 4'd0;
    x.slverr  = err;
    x.prdata  = pr;
    x.wdata   = wd;
    x.addr    = ad;
    return x;
  endfunction

  function automatic logic [31:0] merge_exp(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] s, input logic w1c);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = s[b] ? nw[8*b +: 8] : (w1c ? 8'h00 : old[8*b +: 8]);
    return r;
  endfunction

  function automatic string fmt(input xfer_t x);
    return $sformatf("rdy@A%0d wr@A%0d(x%0d) rd@A%0d(x%0d) slverr=%b prdata=%h wdata=%h addr=%h",
                     x.rdy_cyc, x.wr_cyc, x.wr_n, x.rd_cyc, x.rd_n, x.slverr, x.prdata, x.wdata, x.addr);
  endfunction

  // Called #1 after a rising edge in a free cycle; returns in the cycle after pready.
  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output xfer_t ob);
    ob = '0;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = w;
    apb.paddr = a; apb.pwdata = d; apb.pstrb = s;
    @(posedge clk); #1;
    apb.penable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if ((wr_en || rd_en) && ob.wr_n == 0 && ob.rd_n == 0) ob.addr = addr;
      if (rd_en) begin
        if (ob.rd_n == 0) ob.rd_cyc = 4'(k);
        ob.rd_n++;
      end
      if (wr_en) begin
        if (ob.wr_n == 0) begin ob.wr_cyc = 4'(k); ob.wdata = wdata; end
        ob.wr_n++;
      end
      if (apb.pready) begin
        ob.rdy_cyc = 4'(k);
        ob.prdata  = apb.prdata;
        ob.slverr  = apb.pslverr;
        break;
      end
    end
    @(posedge clk); #1;
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  task automatic backdoor(input int unsigned i, input logic [31:0] v);
    bd_idx = i; bd_val = v; bd_en = 1'b1;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  task automatic test_reset;
    n_chk++;
    if ({apb.prdata, apb.pready, apb.pslverr, wr_en, rd_en, addr, wdata, err_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got prdata=%h pready=%b pslverr=%b wr_en=%b rd_en=%b addr=%h wdata=%h err_count=%h, expected all zero",
               apb.prdata, apb.pready, apb.pslverr, wr_en, rd_en, addr, wdata, err_count);
    end
  endtask

  task automatic test_full_write_read;
    exp_q.push_back(mk(1, 1, 0, 1'b0, 32'h0, 32'h0001_0007, 32'h404));
    exp_q.push_back(mk(3, 0, 1, 1'b0, 32'h0001_0007, 32'h0, 32'h404));
    apb_xfer(1'b1, 32'h404, 32'h0001_0007, 4'hF, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL full_write: got %s, expected %s", fmt(o), fmt(e)); end
    apb_xfer(1'b0, 32'h404, 32'hFFFF_FFFF, 4'h0, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL read_back: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_errors;
    logic [31:0] a [3] = '{32'h414, 32'h428, 32'h402};
    logic        w [3] = '{1'b1, 1'b1, 1'b0};
    int wr0 = wr_total, rd0 = rd_total;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(1, 0, 0, 1'b1, 32'h0, 32'h0, 32'h0));
      if (exp_err < 255) exp_err++;
    end
    for (int i = 0; i < 3; i++) begin
      apb_xfer(w[i], a[i], 32'h1234_5678, 4'hF, o);
      e = exp_q.pop_front(); n_chk++;
      if (o !== e) begin n_err++; $display("FAIL error_%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
    end
    n_chk++;
    if (err_count !== 8'(exp_err)) begin
      n_err++; $display("FAIL err_count_after_errors: got %0d, expected %0d", err_count, exp_err);
    end
    n_chk++;
    if (wr_total != wr0 || rd_total != rd0) begin
      n_err++; $display("FAIL error_strobes: got wr=%0d rd=%0d, expected 0 0", wr_total - wr0, rd_total - rd0);
    end
  endtask

  task automatic test_boundaries;
    backdoor(9, 32'h1234_5678);
    backdoor(5, 32'h0000_5A5A);
    exp_q.push_back(mk(3, 0, 1, 1'b0, 32'h1234_5678, 32'h0, 32'h424));
    exp_q.push_back(mk(3, 0, 1, 1'b0, 32'h0000_5A5A, 32'h0, 32'h414));
    exp_q.push_back(mk(1, 0, 0, 1'b1, 32'h0, 32'h0, 32'h0));
    exp_q.push_back(mk(1, 0, 0, 1'b1, 32'h0, 32'h0, 32'h0));
    exp_err += 2;
    apb_xfer(1'b0, 32'h424, 32'h0, 4'h0, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL last_reg_read: got %s, expected %s", fmt(o), fmt(e)); end
    apb_xfer(1'b0, 32'h414, 32'h0, 4'h0, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL ro_read: got %s, expected %s", fmt(o), fmt(e)); end
    apb_xfer(1'b0, 32'h3FC, 32'h0, 4'h0, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL below_base: got %s, expected %s", fmt(o), fmt(e)); end
    apb_xfer(1'b1, 32'h418, 32'hFFFF_FFFF, 4'h3, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL ro_write: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_rmw;
    int unsigned ok_idx [7] = '{0, 1, 2, 3, 4, 7, 9};
    exp_q.push_back(mk(1, 1, 0, 1'b0, 32'h0, 32'hAABB_CCDD, 32'h408));
    exp_q.push_back(mk(3, 3, 1, 1'b0, 32'h0, 32'hAA22_CC44, 32'h408));
    exp_q.push_back(mk(3, 0, 1, 1'b0, 32'hAA22_CC44, 32'h0, 32'h408));
    apb_xfer(1'b1, 32'h408, 32'hAABB_CCDD, 4'hF, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL rmw_preload: got %s, expected %s", fmt(o), fmt(e)); end
    apb_xfer(1'b1, 32'h408, 32'h1122_3344, 4'b0101, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL rmw_0101: got %s, expected %s", fmt(o), fmt(e)); end
    apb_xfer(1'b0, 32'h408, 32'h0, 4'h0, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL rmw_readback: got %s, expected %s", fmt(o), fmt(e)); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, v, d, m;
      logic [3:0]  s;
      a = 32'h400 + 32'(ok_idx[$urandom_range(0, 6)] * 4);
      v = $urandom; d = $urandom; s = 4'($urandom_range(1, 14));
      m = merge_exp(v, d, s, 1'b0);
      exp_q.push_back(mk(1, 1, 0, 1'b0, 32'h0, v, a));
      exp_q.push_back(mk(3, 3, 1, 1'b0, 32'h0, m, a));
      exp_q.push_back(mk(3, 0, 1, 1'b0, m, 32'h0, a));
      apb_xfer(1'b1, a, v, 4'hF, o);
      e = exp_q.pop_front(); n_chk++;
      if (o !== e) begin n_err++; $display("FAIL rand_preload_%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
      apb_xfer(1'b1, a, d, s, o);
      e = exp_q.pop_front(); n_chk++;
      if (o !== e) begin n_err++; $display("FAIL rand_rmw_%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
      apb_xfer(1'b0, a, 32'h0, 4'h0, o);
      e = exp_q.pop_front(); n_chk++;
      if (o !== e) begin n_err++; $display("FAIL rand_read_%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_w1c;
    backdoor(8, 32'h0000_001F);
    exp_q.push_back(mk(3, 3, 1, 1'b0, 32'h0, 32'h0000_0001, 32'h420));
    exp_q.push_back(mk(3, 0, 1, 1'b0, 32'h0000_001E, 32'h0, 32'h420));
    apb_xfer(1'b1, 32'h420, 32'h0000_0001, 4'b0001, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL w1c_rmw: got %s, expected %s", fmt(o), fmt(e)); end
    apb_xfer(1'b0, 32'h420, 32'h0, 4'h0, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL w1c_readback: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  task automatic test_empty_strobe;
    int wr0 = wr_total, rd0 = rd_total;
    exp_q.push_back(mk(1, 0, 0, 1'b0, 32'h0, 32'h0, 32'h0));
    apb_xfer(1'b1, 32'h40C, 32'hFFFF_FFFF, 4'h0, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL empty_strobe: got %s, expected %s", fmt(o), fmt(e)); end
    n_chk++;
    if (err_count !== 8'(exp_err) || wr_total != wr0 || rd_total != rd0) begin
      n_err++;
      $display("FAIL empty_strobe_side: got err_count=%0d wr=%0d rd=%0d, expected %0d 0 0",
               err_count, wr_total - wr0, rd_total - rd0, exp_err);
    end
  endtask

  task automatic test_err_saturation;
    logic [31:0] bad [3] = '{32'h500, 32'h401, 32'h414};
    int wr0 = wr_total, rd0 = rd_total, rdy0 = rdy_total;
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(mk(1, 0, 0, 1'b1, 32'h0, 32'h0, 32'h0));
      if (exp_err < 255) exp_err++;
      apb_xfer(1'b1, bad[i % 3], 32'(i), 4'hF, o);
      e = exp_q.pop_front(); n_chk++;
      if (o !== e) begin n_err++; $display("FAIL sat_xfer_%0d: got %s, expected %s", i, fmt(o), fmt(e)); end
      if (i == 199) begin
        n_chk++;
        if (err_count !== 8'(exp_err)) begin
          n_err++; $display("FAIL err_count_mid: got %0d, expected %0d", err_count, exp_err);
        end
      end
    end
    n_chk++;
    if (err_count !== 8'hFF) begin
      n_err++; $display("FAIL err_count_saturated: got %h, expected ff", err_count);
    end
    n_chk++;
    if (rdy_total - rdy0 != 300 || wr_total != wr0 || rd_total != rd0) begin
      n_err++;
      $display("FAIL back_to_back_pulses: got pready=%0d wr=%0d rd=%0d, expected 300 0 0",
               rdy_total - rdy0, wr_total - wr0, rd_total - rd0);
    end
  endtask

  task automatic test_reset_mid_rmw;
    int wr0 = wr_total;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = 32'h408; apb.pwdata = 32'h5555_5555; apb.pstrb = 4'b0011;
    @(posedge clk); #1; apb.penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({apb.prdata, apb.pready, apb.pslverr, wr_en, rd_en, addr, wdata, err_count} !== '0) begin
      n_err++;
      $display("FAIL reset_abort: got prdata=%h pready=%b pslverr=%b wr_en=%b rd_en=%b addr=%h wdata=%h err_count=%h, expected all zero",
               apb.prdata, apb.pready, apb.pslverr, wr_en, rd_en, addr, wdata, err_count);
    end
    apb.psel = 1'b0; apb.penable = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_chk++;
    if (wr_total != wr0) begin
      n_err++; $display("FAIL reset_no_write: got %0d wr_en pulses, expected 0", wr_total - wr0);
    end
    exp_err = 0;
    exp_q.push_back(mk(1, 1, 0, 1'b0, 32'h0, 32'hCAFE_F00D, 32'h40C));
    exp_q.push_back(mk(3, 0, 1, 1'b0, 32'hCAFE_F00D, 32'h0, 32'h40C));
    apb_xfer(1'b1, 32'h40C, 32'hCAFE_F00D, 4'hF, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL post_reset_write: got %s, expected %s", fmt(o), fmt(e)); end
    apb_xfer(1'b0, 32'h40C, 32'h0, 4'h0, o);
    e = exp_q.pop_front(); n_chk++;
    if (o !== e) begin n_err++; $display("FAIL post_reset_read: got %s, expected %s", fmt(o), fmt(e)); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion after 300000 time units, expected the bench to finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0; apb.pstrb = '0;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 10; i++) backdoor(i, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_full_write_read();
    test_errors();
    test_boundaries();
    test_rmw();
    test_w1c();
    test_empty_strobe();
    test_err_saturation();
    test_reset_mid_rmw();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
